charactor_ctrl: RTL
===================

CHARACTOR_CTRL -- requirements
Module: charactor_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter STEP_DIV, default 500000, SHALL set the number of clk cycles between movement steps.
REQ-003 Parameter START_H, default 9'd8, SHALL set the character reset and restart horizontal position.
REQ-004 Parameter START_V, default 9'd8, SHALL set the character reset and restart vertical position.
REQ-005 clk  input  1  SHALL be the system clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 state  input  3  SHALL be the game state code: INIT=0, WAIT=1, GAME=2, WIN=3, LOSE=4.
REQ-008 map  input  [0:899]  SHALL be the 20x15 tile map; tile (x,y) SHALL be {map[i],map[i+1],map[i+2]} with i=(x+20*y)*3.
REQ-009 Tile codes SHALL be NONE=0, LINE=1, TERMINAL=2, STAR=3.
REQ-010 key_left, key_right, key_up, key_down  input  1 each  SHALL be synchronous, active-high key levels.
REQ-011 charactor_h  output  9  SHALL be the character centre x in 320-wide space.
REQ-012 charactor_v  output  9  SHALL be the character centre y in 240-high space.
REQ-013 charactor_dir  output  1  SHALL be the facing direction: 0=left, 1=right.
REQ-014 reach_terminal  output  1  SHALL be a one-cycle pulse when the character centre enters a TERMINAL tile.
REQ-015 fall  output  1  SHALL be a one-cycle pulse when the character centre enters a NONE tile.
REQ-016 star_hit  output  1  SHALL be a one-cycle pulse when the character centre enters a new STAR tile.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, RUN, CHECK, HALT.
REQ-018 IDLE: position SHALL be held at (START_H,START_V); the step counter SHALL be held at 0; when state==GAME the FSM SHALL go to RUN on the next cycle.
REQ-019 RUN: a 32-bit step counter SHALL increment every cycle; on reaching STEP_DIV-1 it SHALL wrap to 0 and a step SHALL occur in that same cycle.
REQ-020 Step key priority SHALL be left > right > up > down; only one axis SHALL move per step, by exactly 1 pixel.
REQ-021 No key pressed at a step SHALL leave position unchanged and the FSM in RUN.
REQ-022 Step boundary clamp: a move that would put h outside 7..312 or v outside 7..232 SHALL be suppressed; position SHALL stay unchanged and the FSM SHALL stay in RUN.
REQ-023 A step that moves the character SHALL register the new position and SHALL enter CHECK on the next cycle.
REQ-024 charactor_dir SHALL be set to 0 on any left step and to 1 on any right step, including clamped steps; up/down steps SHALL leave it unchanged.
REQ-025 CHECK SHALL last exactly 1 cycle and SHALL look up tile (charactor_h>>4, charactor_v>>4).
REQ-026 CHECK tile outcomes:
- TERMINAL: pulse reach_terminal, go to HALT.
- NONE: pulse fall, go to HALT.
- STAR: pulse star_hit if the tile index differs from last_star_idx, then update last_star_idx; go to RUN.
- LINE: go to RUN.
REQ-027 The pulse SHALL be asserted during the clk cycle immediately after the CHECK cycle, i.e. a registered output.
REQ-028 The latency from the step cycle to the pulse SHALL be exactly 2 clk cycles.
REQ-029 HALT SHALL hold position and charactor_dir.
REQ-030 If state!=GAME in RUN or CHECK, the FSM SHALL go to HALT and suppress any pending CHECK pulse; the state change SHALL take priority over a simultaneous step.
REQ-031 state==INIT in any FSM state SHALL force IDLE, restore the start position, and clear last_star_idx to 10'h3FF.
REQ-032 HALT with state==GAME and not INIT SHALL stay in HALT.
REQ-033 All arithmetic SHALL use unsigned 9-bit position values; the 10-bit tile index SHALL be computed as x+20*y.

Reset
REQ-034 On rst=1, asynchronously:
- FSM = IDLE
- charactor_h = START_H, charactor_v = START_V
- charactor_dir = 1
- step counter = 0, last_star_idx = 10'h3FF
- reach_terminal, fall, star_hit = 0
REQ-035 Reset asserted mid-step or mid-CHECK SHALL abort with no pulse emitted.

Verification
REQ-036 STEP_DIV=4, map all LINE, state=GAME, key_right held 12 cycles -> charactor_h 8 to 10, charactor_dir=1, no pulses.
REQ-037 Character at (7,8), key_left held -> charactor_h stays 7, charactor_dir=0, FSM stays RUN.
REQ-038 Tile (1,0)=TERMINAL, start (15,8), key_right -> h=16; reach_terminal high 1 cycle exactly 2 cycles after step; FSM in HALT; further keys ignored.
REQ-039 Tile (0,1)=NONE, start (8,15), key_down -> fall pulse once; then state=INIT -> position (8,8), FSM IDLE.
REQ-040 Tiles (1,0) and (2,0)=STAR, key_right held -> exactly one star_hit on entering each tile; none while moving inside the same tile.
REQ-041 state changes GAME to WIN in the same cycle as a step -> no move, no pulse, FSM in HALT.

Source files
------------

// File: rtl/charactor_ctrl.sv
// charactor_ctrl: moves a character over a 20x15 tile map on key input and
// reports tile events (terminal reached, fall, new star) as one-cycle pulses.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | parked at the start position, step counter cleared
//   RUN   | counting towards the next step, keys move the character
//   CHECK | one cycle: classify the tile under the new centre
//   HALT  | frozen until the game state returns to INIT
module charactor_ctrl #(
  parameter int         STEP_DIV = 500000,
  parameter logic [8:0] START_H  = 9'd8,
  parameter logic [8:0] START_V  = 9'd8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   state,
  input  logic [0:899] map,
  input  logic         key_left,
  input  logic         key_right,
  input  logic         key_up,
  input  logic         key_down,
  output logic [8:0]   charactor_h,
  output logic [8:0]   charactor_v,
  output logic         charactor_dir,
  output logic         reach_terminal,
  output logic         fall,
  output logic         star_hit
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_HALT} fsm_t;

  localparam logic [2:0]  GS_INIT   = 3'd0;
  localparam logic [2:0]  GS_GAME   = 3'd2;
  localparam logic [2:0]  T_NONE    = 3'd0;
  localparam logic [2:0]  T_TERM    = 3'd2;
  localparam logic [2:0]  T_STAR    = 3'd3;
  localparam logic [8:0]  H_MIN     = 9'd7;
  localparam logic [8:0]  H_MAX     = 9'd312;
  localparam logic [8:0]  V_MIN     = 9'd7;
  localparam logic [8:0]  V_MAX     = 9'd232;
  localparam logic [31:0] STEP_LAST = 32'(STEP_DIV - 1);
  localparam logic [9:0]  NO_STAR   = 10'h3FF;

  fsm_t        r_fsm;
  logic [8:0]  r_h;
  logic [8:0]  r_v;
  logic        r_dir;
  logic [31:0] r_cnt;
  logic [9:0]  r_last_star;
  logic        r_reach;
  logic        r_fall;
  logic        r_star;

  fsm_t        w_fsm_nxt;
  logic [8:0]  w_h_nxt;
  logic [8:0]  w_v_nxt;
  logic        w_dir_nxt;
  logic [31:0] w_cnt_nxt;
  logic [9:0]  w_last_star_nxt;
  logic        w_reach_nxt;
  logic        w_fall_nxt;
  logic        w_star_nxt;

  logic [4:0]  w_tile_x;
  logic [4:0]  w_tile_y;
  logic [9:0]  w_tile_idx;
  logic [9:0]  w_tile_bit;
  logic [2:0]  w_tile;

  // Tile under the current (registered) centre; only consumed in CHECK.
  assign w_tile_x   = r_h[8:4];
  assign w_tile_y   = r_v[8:4];
  assign w_tile_idx = {5'd0, w_tile_x} + ({5'd0, w_tile_y} * 10'd20);
  assign w_tile_bit = w_tile_idx * 10'd3;
  assign w_tile     = map[w_tile_bit +: 3];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= S_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  // Next-state, movement and pulse decisions; INIT overrides everything.
  always_comb begin
    w_fsm_nxt       = r_fsm;
    w_h_nxt         = r_h;
    w_v_nxt         = r_v;
    w_dir_nxt       = r_dir;
    w_cnt_nxt       = r_cnt;
    w_last_star_nxt = r_last_star;
    w_reach_nxt     = 1'b0;
    w_fall_nxt      = 1'b0;
    w_star_nxt      = 1'b0;
    if (state == GS_INIT) begin
      w_fsm_nxt       = S_IDLE;
      w_h_nxt         = START_H;
      w_v_nxt         = START_V;
      w_cnt_nxt       = 32'd0;
      w_last_star_nxt = NO_STAR;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          w_h_nxt   = START_H;
          w_v_nxt   = START_V;
          w_cnt_nxt = 32'd0;
          if (state == GS_GAME) w_fsm_nxt = S_RUN;
        end
        S_RUN: begin
          // Leaving GAME wins over a step landing in the same cycle.
          if (state != GS_GAME) begin
            w_fsm_nxt = S_HALT;
          end else if (r_cnt == STEP_LAST) begin
            w_cnt_nxt = 32'd0;
            if (key_left) begin
              w_dir_nxt = 1'b0;
              if (r_h > H_MIN) begin
                w_h_nxt   = r_h - 9'd1;
                w_fsm_nxt = S_CHECK;
              end
            end else if (key_right) begin
              w_dir_nxt = 1'b1;
              if (r_h < H_MAX) begin
                w_h_nxt   = r_h + 9'd1;
                w_fsm_nxt = S_CHECK;
              end
            end else if (key_up) begin
              if (r_v > V_MIN) begin
                w_v_nxt   = r_v - 9'd1;
                w_fsm_nxt = S_CHECK;
              end
            end else if (key_down) begin
              if (r_v < V_MAX) begin
                w_v_nxt   = r_v + 9'd1;
                w_fsm_nxt = S_CHECK;
              end
            end
          end else begin
            w_cnt_nxt = r_cnt + 32'd1;
          end
        end
        S_CHECK: begin
          if (state != GS_GAME) begin
            w_fsm_nxt = S_HALT;
          end else begin
            case (w_tile)
              T_TERM: begin
                w_reach_nxt = 1'b1;
                w_fsm_nxt   = S_HALT;
              end
              T_NONE: begin
                w_fall_nxt = 1'b1;
                w_fsm_nxt  = S_HALT;
              end
              T_STAR: begin
                w_star_nxt      = (w_tile_idx != r_last_star);
                w_last_star_nxt = w_tile_idx;
                w_fsm_nxt       = S_RUN;
              end
              default: w_fsm_nxt = S_RUN;
            endcase
          end
        end
        S_HALT: w_fsm_nxt = S_HALT;
        default: w_fsm_nxt = S_IDLE;
      endcase
    end
  end

  // Position, direction, step counter, star memory and registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h         <= START_H;
      r_v         <= START_V;
      r_dir       <= 1'b1;
      r_cnt       <= 32'd0;
      r_last_star <= NO_STAR;
      r_reach     <= 1'b0;
      r_fall      <= 1'b0;
      r_star      <= 1'b0;
    end else begin
      r_h         <= w_h_nxt;
      r_v         <= w_v_nxt;
      r_dir       <= w_dir_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last_star <= w_last_star_nxt;
      r_reach     <= w_reach_nxt;
      r_fall      <= w_fall_nxt;
      r_star      <= w_star_nxt;
    end
  end

  assign charactor_h    = r_h;
  assign charactor_v    = r_v;
  assign charactor_dir  = r_dir;
  assign reach_terminal = r_reach;
  assign fall           = r_fall;
  assign star_hit       = r_star;

endmodule
